// File: rtl/num_entry.sv
// Button/switch front end for num_detector: synchronises, debounces and edge-detects
// up/down/load buttons and steps or loads a registered WIDTH-bit value.
module num_entry #(
    parameter int               WIDTH           = 5,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter bit               WRAP            = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] number,
    output logic             changed
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam int               UP       = 0;
    localparam int               DOWN     = 1;
    localparam int               LOAD     = 2;

    logic [2:0]             btn_raw;
    logic [2:0]             btn_sync1_q, btn_sync1_d;
    logic [2:0]             btn_sync2_q, btn_sync2_d;
    logic [WIDTH-1:0]       sw_sync1_q, sw_sync1_d;
    logic [WIDTH-1:0]       sw_sync2_q, sw_sync2_d;
    logic [2:0]             deb_q, deb_d;
    logic [2:0]             deb_prev_q, deb_prev_d;
    logic [2:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]             press;
    logic [WIDTH-1:0]       number_q, number_d;
    logic                   changed_q, changed_d;

    assign btn_raw = {btn_load, btn_down, btn_up};

    // The toggle happens on the DEBOUNCE_CYCLES-th consecutive mismatching sample,
    // so the stored count never needs to hold DEBOUNCE_CYCLES itself.
    always_comb begin
        btn_sync1_d = btn_raw;
        btn_sync2_d = btn_sync1_q;
        sw_sync1_d  = sw;
        sw_sync2_d  = sw_sync1_q;
        deb_prev_d  = deb_q;
        deb_d       = deb_q;
        cnt_d       = '0;
        for (int i = 0; i < 3; i++) begin
            if (btn_sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    // Load beats stepping; simultaneous up and down cancel out.
    always_comb begin
        number_d = number_q;
        if (press[LOAD]) begin
            number_d = sw_sync2_q;
        end else if (press[UP] && press[DOWN]) begin
            number_d = number_q;
        end else if (press[UP]) begin
            if (WRAP || number_q != MAX_VAL) begin
                number_d = number_q + 1'b1;
            end
        end else if (press[DOWN]) begin
            if (WRAP || number_q != '0) begin
                number_d = number_q - 1'b1;
            end
        end
        changed_d = (number_d != number_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync1_q <= '0;
            btn_sync2_q <= '0;
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            cnt_q       <= '0;
            number_q    <= RESET_VALUE;
            changed_q   <= 1'b0;
        end else begin
            btn_sync1_q <= btn_sync1_d;
            btn_sync2_q <= btn_sync2_d;
            sw_sync1_q  <= sw_sync1_d;
            sw_sync2_q  <= sw_sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            cnt_q       <= cnt_d;
            number_q    <= number_d;
            changed_q   <= changed_d;
        end
    end

    assign number  = number_q;
    assign changed = changed_q;

endmodule
